inv_sub_bytes_iter: RTL and testbench
=====================================

INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 Parameter: BYTES_PER_CYCLE, default 4, number of state bytes inverse-substituted per clock; legal values 1, 2, 4, 8, 16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  in_data holds a 128-bit AES state to transform.
REQ-005 Port: in_ready  output  1  block can accept a new state.
REQ-006 Port: in_data  input  128  AES state; byte 0 = [127:120], byte 15 = [7:0].
REQ-007 Port: out_valid  output  1  out_data holds a completed InvSubBytes result.
REQ-008 Port: out_ready  input  1  downstream accepts out_data.
REQ-009 Port: out_data  output  128  InvSubBytes(in_data), same byte ordering as in_data.
REQ-010 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 Each output byte SHALL equal the FIPS-197 inverse S-box of the corresponding input byte (e.g. 0x63->0x00, 0x7C->0x01, 0x00->0x52, 0x16->0xFF, 0xED->0x53).
REQ-012 FSM SHALL have exactly three states: IDLE, SUB, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture in_data into the working register, clear chunk counter to 0, go to SUB.
REQ-014 SUB: in_ready=0, out_valid=0; each cycle replace chunk cnt of the working register with its inverse substitution and increment cnt.
REQ-015 Chunk cnt SHALL cover bytes [cnt*BYTES_PER_CYCLE .. cnt*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1], processed MSB byte first; each byte substituted exactly once.
REQ-016 Counter width SHALL be ceil(log2(16/BYTES_PER_CYCLE)), min 1 bit; at cnt = 16/BYTES_PER_CYCLE-1, transition SUB->DONE on the same edge as the final chunk write.
REQ-017 Latency: out_valid SHALL rise exactly 16/BYTES_PER_CYCLE clock edges after the accepting edge (4 with default).
REQ-018 DONE: out_valid=1, in_ready=0; out_data SHALL remain stable while out_valid&&!out_ready.
REQ-019 DONE with out_ready=1: handshake completes on that edge, go to IDLE; out_valid low next cycle.
REQ-020 in_ready SHALL depend only on state, never combinationally on out_ready; no new state accepted in the DONE->IDLE handshake cycle (one bubble cycle minimum between results).
REQ-021 in_valid and in_data SHALL be ignored whenever in_ready=0.
REQ-022 out_data SHALL be driven from the working register; value is defined only while out_valid=1.
REQ-023 BYTES_PER_CYCLE not in {1,2,4,8,16} SHALL cause an elaboration-time error.
REQ-024 Inverse S-box SHALL be combinational lookup, BYTES_PER_CYCLE instances, no memory macros.

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) force state=IDLE, cnt=0, working register=0, out_valid=0, busy=0; in_ready=1 after the block leaves reset.
REQ-026 Reset asserted in SUB or DONE SHALL abort the transform and discard the partial state; no out_valid pulse is produced for it.
REQ-027 First accept after rst_n deasserts SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-028 Default param, in_data=637c777bf26b6fc53001672bfed7ab76, out_ready=1 -> out_valid rises 4 edges after accept, out_data=000102030405060708090a0b0c0d0e0f, then IDLE.
REQ-029 in_data=all 0x00 then all 0x16 back-to-back, out_ready=1 -> results all 0x52 then all 0xFF; in_ready=0 throughout SUB/DONE, one bubble cycle between.
REQ-030 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable all 10 cycles; in_valid pulses with different data ignored; result delivered on out_ready=1.
REQ-031 rst_n pulsed low mid-SUB (after 2 chunks) -> outputs return to reset values asynchronously, no out_valid; next transform of 63636363...63 yields all 0x00.
REQ-032 Sweep BYTES_PER_CYCLE in {1,2,4,8,16} with random inputs vs. reference model -> latency 16/8/4/2/1 edges, all 256 byte values exercised, outputs match.

Source files
------------

// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative AES InvSubBytes, BYTES_PER_CYCLE bytes per clock
module inv_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int CHUNKS = 16 / BYTES_PER_CYCLE;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CB     = BYTES_PER_CYCLE * 8;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("BYTES_PER_CYCLE must be one of 1, 2, 4, 8, 16");
  end

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [127:0]    work;
  logic [CB-1:0]   chunk_in;
  logic [CB-1:0]   chunk_out;
  logic [127:0]    work_next;
  logic            last_chunk;

  // The working register rotates left one chunk per cycle, so the chunk being
  // substituted is always the top slice and a full pass restores byte order.
  assign chunk_in = work[127 -: CB];

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
    assign chunk_out[CB-1-8*j -: 8] = inv_sbox(chunk_in[CB-1-8*j -: 8]);
  end

  if (CB == 128) begin : g_full
    assign work_next = chunk_out;
  end else begin : g_rot
    assign work_next = {work[127-CB:0], chunk_out};
  end

  assign last_chunk = (cnt == CW'(CHUNKS - 1));
  assign out_data   = work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= in_data;
            cnt      <= '0;
            state    <= SUB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SUB: begin
          work <= work_next;
          if (last_chunk) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - randomized bench for inv_sub_bytes_iter across all widths
module tb_inv_sub_bytes_iter;

  localparam int NI = 5;
  localparam int BPC [NI] = '{1, 2, 4, 8, 16};
  localparam int KD = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv   [NI];
  logic         ir   [NI];
  logic         ov   [NI];
  logic         ordy [NI];
  logic         bsy  [NI];
  logic [127:0] id   [NI];
  logic [127:0] od   [NI];

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    if (BPC[g] == 4) begin : g_def
      inv_sub_bytes_iter u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
        .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]), .busy(bsy[g])
      );
    end else begin : g_par
      inv_sub_bytes_iter #(.BYTES_PER_CYCLE(BPC[g])) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
        .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]), .busy(bsy[g])
      );
    end
  end

  // Reference: forward S-box from GF(2^8) inversion plus affine map, then inverted.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] x, y, inv, s;
    for (int xi = 0; xi < 256; xi++) begin
      x = 8'(xi);
      inv = 8'h00;
      for (int yi = 1; yi < 256; yi++) begin
        y = 8'(yi);
        if (x != 8'h00 && gmul(x, y) == 8'h01) inv = y;
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      inv_tab[s] = x;
    end
  endtask

  function automatic logic [127:0] ref_model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[d[127-8*i -: 8]];
    return r;
  endfunction

  task automatic run_one(input int k, input logic [127:0] d, input int stall,
                         output logic [127:0] res, output int lat);
    logic [127:0] held;
    ordy[k] = (stall == 0);
    vectors++;
    if (ir[k] !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready bpc=%0d got %b want 1", BPC[k], ir[k]);
    end
    iv[k] = 1'b1;
    id[k] = d;
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0;
    id[k] = {4{$urandom}};
    lat = 0;
    while (ov[k] !== 1'b1 && lat < 64) begin
      vectors++;
      if (ir[k] !== 1'b0 || bsy[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL sub_flags bpc=%0d in_ready=%b busy=%b want 0/1", BPC[k], ir[k], bsy[k]);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (ov[k] !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout bpc=%0d out_valid=%b want 1", BPC[k], ov[k]);
    end
    held = od[k];
    for (int s = 0; s < stall; s++) begin
      vectors++;
      if (ov[k] !== 1'b1 || od[k] !== held || ir[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold bpc=%0d cyc=%0d valid=%b ready=%b data=%h want 1/0/%h",
                 BPC[k], s, ov[k], ir[k], od[k], held);
      end
      iv[k] = s[0];
      id[k] = {4{$urandom}};
      @(posedge clk);
      @(negedge clk);
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    vectors++;
    if (ov[k] !== 1'b1 || od[k] !== held) begin
      miscompares++;
      $display("FAIL handshake_data bpc=%0d valid=%b data=%h want 1/%h", BPC[k], ov[k], od[k], held);
    end
    res = od[k];
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || bsy[k] !== 1'b0) begin
      miscompares++;
      $display("FAIL after_handshake bpc=%0d valid=%b ready=%b busy=%b want 0/1/0",
               BPC[k], ov[k], ir[k], bsy[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (ov[k] !== 1'b0 || bsy[k] !== 1'b0 || od[k] !== 128'h0 || ir[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state bpc=%0d valid=%b busy=%b ready=%b data=%h want 0/0/1/0",
                 BPC[k], ov[k], bsy[k], ir[k], od[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_known_vector();
    logic [127:0] res;
    int lat;
    run_one(KD, 128'h637c777bf26b6fc53001672bfed7ab76, 0, res, lat);
    vectors++;
    if (res !== 128'h000102030405060708090a0b0c0d0e0f || lat != 4) begin
      miscompares++;
      $display("FAIL known_vector got %h lat %0d want 000102030405060708090a0b0c0d0e0f lat 4", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got [2];
    int nres = 0, nacc = 0, cyc = 0, t0 = 0, t1 = 0;
    logic acc;
    ordy[KD] = 1'b1;
    iv[KD] = 1'b1;
    id[KD] = {16{8'h00}};
    while (nres < 2 && cyc < 40) begin
      if (bsy[KD] === 1'b1) begin
        vectors++;
        if (ir[KD] !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_ready_busy cyc=%0d in_ready=%b want 0", cyc, ir[KD]);
        end
      end
      if (ov[KD] === 1'b1) begin
        got[nres] = od[KD];
        nres++;
      end
      acc = iv[KD] && ir[KD];
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (nacc == 0) begin
          t0 = cyc;
          id[KD] = {16{8'h16}};
        end else begin
          t1 = cyc;
          iv[KD] = 1'b0;
        end
        nacc++;
      end
    end
    iv[KD] = 1'b0;
    vectors++;
    if (nres != 2 || got[0] !== {16{8'h52}} || got[1] !== {16{8'hff}}) begin
      miscompares++;
      $display("FAIL b2b_results count=%0d r0=%h r1=%h want 2 results of 52s then ffs", nres, got[0], got[1]);
    end
    vectors++;
    if (t1 - t0 != 6) begin
      miscompares++;
      $display("FAIL b2b_spacing got %0d edges want 6", t1 - t0);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, res;
    int lat;
    d = {4{$urandom}};
    run_one(KD, d, 10, res, lat);
    vectors++;
    if (res !== ref_model(d) || lat != 4) begin
      miscompares++;
      $display("FAIL backpressure got %h lat %0d want %h lat 4", res, lat, ref_model(d));
    end
  endtask

  task automatic test_reset_mid_sub();
    logic [127:0] res;
    int lat;
    iv[KD] = 1'b1;
    id[KD] = {4{$urandom}};
    @(posedge clk);
    @(negedge clk);
    iv[KD] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ov[KD] !== 1'b0 || bsy[KD] !== 1'b0 || od[KD] !== 128'h0 || ir[KD] !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset valid=%b busy=%b ready=%b data=%h want 0/0/1/0",
               ov[KD], bsy[KD], ir[KD], od[KD]);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (ov[KD] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_valid got %b want 0", ov[KD]);
    end
    rst_n = 1'b1;
    run_one(KD, {16{8'h63}}, 0, res, lat);
    vectors++;
    if (res !== 128'h0 || lat != 4) begin
      miscompares++;
      $display("FAIL post_reset_vector got %h lat %0d want 0 lat 4", res, lat);
    end
  endtask

  task automatic test_sweep();
    logic [127:0] d, res;
    int lat;
    for (int k = 0; k < NI; k++) begin
      for (int v = 0; v < 24; v++) begin
        if (v < 16) begin
          for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'(v * 16 + i);
        end else begin
          d = {4{$urandom}};
        end
        run_one(k, d, int'($urandom_range(0, 2)), res, lat);
        vectors++;
        if (res !== ref_model(d) || lat != 16 / BPC[k]) begin
          miscompares++;
          $display("FAIL sweep bpc=%0d v=%0d got %h lat %0d want %h lat %0d",
                   BPC[k], v, res, lat, ref_model(d), 16 / BPC[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
      id[k] = '0;
    end
    build_tables();
    @(negedge clk);
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_sub();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
